// File: rtl/nmea_pkg.sv
// nmea_pkg: shared parser states, ASCII constants and helpers for the NMEA VTG speed extractor
package nmea_pkg;
  typedef enum logic [2:0] {IDLE, HDR, FIELD, CK1, CK2} state_t;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_STAR = 8'h2A;
  localparam logic [7:0] CH_DOT = 8'h2E;
  localparam logic [7:0] CH_0 = 8'h30;
  localparam logic [7:0] CH_9 = 8'h39;
  localparam int KMH_FIELD_IDX = 7;
  function automatic logic is_alpha(input logic [7:0] c);
    return (c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A);
  endfunction
endpackage

// File: rtl/ascii_hex_decode.sv
// ascii_hex_decode: maps an ASCII hex digit (either case) to its 4-bit value plus a validity flag
module ascii_hex_decode
  import nmea_pkg::*;
(
  input  logic [7:0] ascii_i,
  output logic [3:0] value_o,
  output logic       is_hex_o
);
  logic dig, up, lo;
  always_comb begin
    dig = ascii_i >= CH_0 && ascii_i <= CH_9;
    up = ascii_i >= 8'h41 && ascii_i <= 8'h46;
    lo = ascii_i >= 8'h61 && ascii_i <= 8'h66;
    is_hex_o = dig | up | lo;
    value_o = dig ? ascii_i[3:0] : ascii_i[3:0] + 4'd9;
  end
endmodule

// File: rtl/nmea_vtg_speed.sv
// nmea_vtg_speed: extracts the km/h field of $xxVTG sentences from a byte stream.
// NMEA_CHECKSUM_EN enables checksum verification; otherwise sentences complete at '*'.
module nmea_vtg_speed
  import nmea_pkg::*;
#(
  parameter int MAX_SPEED_P = 99,
  parameter int MAX_LEN_P = 82
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic       rx_ready_o,
  output logic [7:0] speed_o,
  output logic       speed_valid_o
);
  localparam logic [11:0] MAX_SPD = 12'(MAX_SPEED_P);
  localparam logic [7:0] MAX_LEN = 8'(MAX_LEN_P);
`ifdef NMEA_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif
  state_t state_q, state_d;
  logic [2:0] hdr_q, hdr_d;
  logic [7:0] len_q, len_d, len_n;
  logic [3:0] comma_q, comma_d;
  logic [11:0] acc_q, acc_d, acc_n;
  logic frac_q, frac_d, dig_q, dig_d;
  logic [7:0] speed_q, speed_d;
  logic pulse_q, pulse_d;
  logic xfer, is_dig, hdr_ok, done, drop, ck1_ok, ck2_ok;
  assign rx_ready_o = ~reset_i;
  assign xfer = rx_valid_i & rx_ready_o;
  assign is_dig = rx_data_i >= CH_0 && rx_data_i <= CH_9;
  assign len_n = len_q + 8'd1;
  assign acc_n = acc_q * 12'd10 + {8'd0, rx_data_i[3:0]};
  assign hdr_ok = hdr_q < 3'd2 ? is_alpha(rx_data_i)
                : rx_data_i == (hdr_q == 3'd2 ? 8'h56 : hdr_q == 3'd3 ? 8'h54 : 8'h47);
`ifdef NMEA_CHECKSUM_EN
  logic [7:0] cks_q, cks_d;
  logic [3:0] hi_q, hi_d, hex_val;
  logic hex_ok;
  ascii_hex_decode u_hex (.ascii_i(rx_data_i), .value_o(hex_val), .is_hex_o(hex_ok));
  always_comb begin
    cks_d = cks_q;
    hi_d = hi_q;
    if (xfer && rx_data_i == CH_DOLLAR) cks_d = '0;
    else if (xfer && (state_q == HDR || (state_q == FIELD && rx_data_i != CH_STAR))) cks_d = cks_q ^ rx_data_i;
    if (xfer && state_q == CK1) hi_d = hex_val;
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cks_q <= '0;
      hi_q <= '0;
    end else begin
      cks_q <= cks_d;
      hi_q <= hi_d;
    end
  end
  assign ck1_ok = hex_ok;
  assign ck2_ok = hex_ok && {hi_q, hex_val} == cks_q;
`else
  assign ck1_ok = 1'b1;
  assign ck2_ok = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    hdr_d = hdr_q;
    len_d = len_q;
    comma_d = comma_q;
    acc_d = acc_q;
    frac_d = frac_q;
    dig_d = dig_q;
    done = 1'b0;
    drop = 1'b0;
    if (xfer && rx_data_i == CH_DOLLAR) begin
      state_d = HDR;
      hdr_d = '0;
      len_d = 8'd1;
      comma_d = '0;
      acc_d = '0;
      frac_d = 1'b0;
      dig_d = 1'b0;
    end else if (xfer && state_q != IDLE) begin
      len_d = len_n;
      case (state_q)
        HDR: begin
          hdr_d = hdr_q + 3'd1;
          drop = ~hdr_ok;
          state_d = hdr_q == 3'd4 ? FIELD : HDR;
        end
        FIELD: begin
          if (rx_data_i == CH_STAR) begin
            drop = comma_q < 4'(KMH_FIELD_IDX + 1);
            done = ~CK_EN && !drop;
            state_d = CK1;
          end else if (rx_data_i == CH_COMMA) begin
            drop = comma_q == 4'(KMH_FIELD_IDX) && !dig_q;
            comma_d = comma_q == 4'hF ? comma_q : comma_q + 4'd1;
          end else if (comma_q == 4'(KMH_FIELD_IDX) && !frac_q) begin
            // after '.', everything up to the next comma is ignored
            drop = !(is_dig || (rx_data_i == CH_DOT && dig_q));
            frac_d = rx_data_i == CH_DOT;
            dig_d = 1'b1;
            acc_d = is_dig ? (acc_n > MAX_SPD ? MAX_SPD : acc_n) : acc_q;
          end
        end
        CK1: begin
          drop = ~ck1_ok;
          state_d = CK2;
        end
        CK2: begin
          done = CK_EN && ck2_ok;
          state_d = IDLE;
        end
        default: ;
      endcase
      if (len_n >= MAX_LEN && !done) drop = 1'b1;
      if (drop) state_d = IDLE;
    end
    speed_d = done ? acc_q[7:0] : speed_q;
    pulse_d = done;
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      hdr_q <= '0;
      len_q <= '0;
      comma_q <= '0;
      acc_q <= '0;
      frac_q <= 1'b0;
      dig_q <= 1'b0;
      speed_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hdr_q <= hdr_d;
      len_q <= len_d;
      comma_q <= comma_d;
      acc_q <= acc_d;
      frac_q <= frac_d;
      dig_q <= dig_d;
      speed_q <= speed_d;
      pulse_q <= pulse_d;
    end
  end
  assign speed_o = speed_q;
  assign speed_valid_o = pulse_q;
endmodule

// File: tb/tb_nmea_vtg_speed.sv
// tb_nmea_vtg_speed: directed table, corner sequences and random sentences against a string-level model
module tb_nmea_vtg_speed;
  localparam int MAX_SPD = 99;
  localparam int MAX_LEN = 82;
`ifdef NMEA_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
  localparam int OVH = 4;
`else
  localparam bit CK_EN = 1'b0;
  localparam int OVH = 2;
`endif
  typedef struct {
    string name;
    string s;
    bit    pulse;
    int    spd;
  } vec_t;
  logic clk_i = 1'b0;
  logic reset_i = 1'b1;
  logic rx_valid_i = 1'b0;
  logic [7:0] rx_data_i = 8'd0;
  logic rx_ready_o, speed_valid_o;
  logic [7:0] speed_o;
  logic [7:0] hx_in = 8'd0;
  logic [3:0] hx_val;
  logic hx_ok;
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  nmea_vtg_speed #(.MAX_SPEED_P(MAX_SPD), .MAX_LEN_P(MAX_LEN)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .rx_ready_o(rx_ready_o), .speed_o(speed_o), .speed_valid_o(speed_valid_o)
  );
  ascii_hex_decode u_hx (.ascii_i(hx_in), .value_o(hx_val), .is_hex_o(hx_ok));
  always #5 clk_i = ~clk_i;
  always @(negedge clk_i) if (speed_valid_o) pulses <= pulses + 1;
  initial begin
    #2000000;
    $display("FAIL watchdog expired got 0 want 1");
    $fatal(1);
  end
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask
  function automatic int hexv(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
    if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
    if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
    return -1;
  endfunction
  function automatic bit alpha(input logic [7:0] c);
    return (c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A);
  endfunction
  function automatic logic [7:0] xsum(input string b);
    logic [7:0] x;
    x = 8'd0;
    for (int i = 0; i < b.len(); i++) x = x ^ b[i];
    return x;
  endfunction
  function automatic string mk(input string body, input bit bad, input bit lower);
    logic [7:0] x;
    string h;
    x = xsum(body) ^ {7'd0, bad};
    h = lower ? $sformatf("%02x", x) : $sformatf("%02X", x);
    return {"$", body, "*", h, "\015\012"};
  endfunction
  function automatic string vtg(input string km);
    return {"GPVTG,054.7,T,034.4,M,005.5,N,", km, ",K,A"};
  endfunction
  function automatic string pad(input int n);
    string b;
    b = "GPVTG,0,T,0,M,0,N,33,K,A";
    while (b.len() < n - OVH) b = {b, "A"};
    return mk(b, 1'b0, 1'b0);
  endfunction
  function automatic void eval_seg(input string seg, output bit ok, output int spd);
    int p, c, f0, f1, v, nd;
    ok = 1'b0;
    spd = 0;
    p = -1;
    for (int i = 0; i < seg.len() && p < 0; i++) if (seg[i] == 8'h2A) p = i;
    if (p < 5) return;
    if (CK_EN ? (seg.len() < p + 3 || p + 4 > MAX_LEN) : (p + 2 > MAX_LEN)) return;
    if (!alpha(seg[0]) || !alpha(seg[1]) || seg.substr(2, 4) != "VTG") return;
    c = 0;
    f0 = 0;
    f1 = 0;
    for (int i = 0; i < p; i++)
      if (seg[i] == 8'h2C) begin
        c++;
        if (c == 7) f0 = i + 1;
        if (c == 8) f1 = i;
      end
    if (c < 8) return;
    v = 0;
    nd = 0;
    for (int i = f0; i < f1 && seg[i] != 8'h2E; i++) begin
      if (seg[i] < 8'h30 || seg[i] > 8'h39) return;
      v = v > 100000 ? v : v * 10 + (int'(seg[i]) - 48);
      nd++;
    end
    if (nd == 0) return;
    if (CK_EN) begin
      if (hexv(seg[p+1]) < 0 || hexv(seg[p+2]) < 0) return;
      if (hexv(seg[p+1]) * 16 + hexv(seg[p+2]) != int'(xsum(seg.substr(0, p - 1)))) return;
    end
    ok = 1'b1;
    spd = v > MAX_SPD ? MAX_SPD : v;
  endfunction
  function automatic void model(input string s, inout int spd, output int cnt);
    cnt = 0;
    for (int i = 0; i < s.len(); i++)
      if (s[i] == 8'h24) begin
        int j, v;
        bit ok;
        j = i + 1;
        while (j < s.len() && s[j] != 8'h24) j++;
        eval_seg(s.substr(i + 1, j - 1), ok, v);
        if (ok) begin
          cnt++;
          spd = v;
        end
      end
  endfunction
  function automatic string rand_sentence();
    int kind, nd;
    string km, tl, body, s;
    kind = $urandom_range(0, 11);
    km = "";
    nd = $urandom_range(0, 4);
    for (int i = 0; i < nd; i++) km = {km, $sformatf("%0d", $urandom_range(0, 9))};
    if ($urandom_range(0, 2) == 0) km = {km, ".", $sformatf("%0d", $urandom_range(0, 9))};
    if (kind == 0) km = {km, "x"};
    tl = kind == 1 ? "RMC" : "VTG";
    tl = {$sformatf("%c", 8'(65 + $urandom_range(0, 25))), $sformatf("%c", 8'(65 + $urandom_range(0, 25))), tl};
    body = kind == 2 ? {tl, ",1,T,2,M,3,N,", km} : {tl, ",054.7,T,034.4,M,005.5,N,", km, ",K,A"};
    if (kind == 3) for (int i = $urandom_range(0, 40); i > 0; i--) body = {body, "A"};
    s = mk(body, kind == 4, 1'($urandom_range(0, 1)));
    if (kind == 5) s = {"$GPVTG,1,", s};
    return s;
  endfunction
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int g;
    g = gaps ? $urandom_range(0, 2) : 0;
    repeat (g) begin
      rx_valid_i = 1'b0;
      rx_data_i = 8'($urandom_range(0, 255));
      @(posedge clk_i);
      #1;
    end
    rx_data_i = b;
    rx_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    rx_valid_i = 1'b0;
  endtask
  task automatic send_str(input string s, input int from, input int to, input bit gaps);
    for (int i = from; i < to; i++) send_byte(s[i], gaps);
  endtask
  task automatic settle();
    repeat (3) @(posedge clk_i);
    #1;
  endtask
  initial begin
    vec_t tbl[$];
    string s;
    int prev, p0, k, exp, cnt;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_speed", speed_o, 0);
    check("rst_valid", speed_valid_o, 0);
    check("rst_ready", rx_ready_o, 0);
    reset_i = 1'b0;
    #1;
    check("ready_after_rst", rx_ready_o, 1);
    for (int c = 0; c < 256; c++) begin
      hx_in = 8'(c);
      #1;
      check($sformatf("hex_ok_%0d", c), hx_ok, int'(hexv(8'(c)) >= 0));
      if (hexv(8'(c)) >= 0) check($sformatf("hex_val_%0d", c), hx_val, hexv(8'(c)));
    end
    tbl.push_back('{"base", mk(vtg("010.2"), 1'b0, 1'b0), 1'b1, 10});
    tbl.push_back('{"saturate", mk(vtg("123.4"), 1'b0, 1'b0), 1'b1, 99});
    tbl.push_back('{"lead_zero", mk(vtg("007"), 1'b0, 1'b0), 1'b1, 7});
    tbl.push_back('{"empty_kmh", mk(vtg(""), 1'b0, 1'b0), 1'b0, 0});
    tbl.push_back('{"bad_cksum", mk(vtg("055"), 1'b1, 1'b0), !CK_EN, 55});
    tbl.push_back('{"restart", {"$GPVTG,1,T,", mk("GNVTG,054.7,T,034.4,M,005.5,N,042,K,A", 1'b0, 1'b0)}, 1'b1, 42});
    tbl.push_back('{"rmc", mk("GPRMC,123519,A,4807.038,N,01131.000,E,022.4,084.4,230394,003.1,W", 1'b0, 1'b0), 1'b0, 0});
    tbl.push_back('{"bad_char", mk(vtg("1x"), 1'b0, 1'b0), 1'b0, 0});
    tbl.push_back('{"dot_first", mk(vtg(".5"), 1'b0, 1'b0), 1'b0, 0});
    tbl.push_back('{"few_commas", mk("GPVTG,054.7,T,034.4,M,005.5,N,010", 1'b0, 1'b0), 1'b0, 0});
    tbl.push_back('{"lower_hex", mk(vtg("088"), 1'b0, 1'b1), 1'b1, 88});
    tbl.push_back('{"hundred", mk(vtg("100"), 1'b0, 1'b0), 1'b1, 99});
    tbl.push_back('{"ceiling", mk(vtg("99.9"), 1'b0, 1'b0), 1'b1, 99});
    tbl.push_back('{"zero", mk(vtg("0"), 1'b0, 1'b0), 1'b1, 0});
    tbl.push_back('{"len_max", pad(MAX_LEN), 1'b1, 33});
    tbl.push_back('{"len_over", pad(MAX_LEN + 1), 1'b0, 0});
    tbl.push_back('{"talker_ga", mk("GAVTG,1,T,2,M,3,N,61,K,A", 1'b0, 1'b0), 1'b1, 61});
    tbl.push_back('{"hdr_digit", mk("G1VTG,1,T,2,M,3,N,61,K,A", 1'b0, 1'b0), 1'b0, 0});
    prev = 0;
    foreach (tbl[i]) begin
      p0 = pulses;
      send_str(tbl[i].s, 0, tbl[i].s.len(), 1'b1);
      settle();
      exp = tbl[i].pulse ? tbl[i].spd : prev;
      check({tbl[i].name, "_pulses"}, pulses - p0, int'(tbl[i].pulse));
      check({tbl[i].name, "_speed"}, speed_o, exp);
      prev = exp;
    end
    s = mk(vtg("021"), 1'b0, 1'b0);
    k = CK_EN ? s.len() - 3 : s.len() - 5;
    send_str(s, 0, k, 1'b0);
    check("timing_pre", speed_valid_o, 0);
    send_byte(s[k], 1'b0);
    check("timing_pulse", speed_valid_o, 1);
    check("timing_speed", speed_o, 21);
    @(posedge clk_i);
    #1;
    check("timing_single", speed_valid_o, 0);
    send_str(s, k + 1, s.len(), 1'b0);
    s = mk(vtg("064"), 1'b0, 1'b0);
    send_str(s, 0, 20, 1'b1);
    reset_i = 1'b1;
    #2;
    check("midrst_speed", speed_o, 0);
    check("midrst_ready", rx_ready_o, 0);
    check("midrst_valid", speed_valid_o, 0);
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    p0 = pulses;
    send_str(s, 20, s.len(), 1'b1);
    settle();
    check("midrst_tail_pulses", pulses - p0, 0);
    check("midrst_tail_speed", speed_o, 0);
    p0 = pulses;
    send_str(s, 0, s.len(), 1'b1);
    settle();
    check("midrst_next_pulses", pulses - p0, 1);
    check("midrst_next_speed", speed_o, 64);
    prev = 64;
    for (int n = 0; n < 60; n++) begin
      s = rand_sentence();
      exp = prev;
      model(s, exp, cnt);
      p0 = pulses;
      send_str(s, 0, s.len(), 1'($urandom_range(0, 1)));
      settle();
      check($sformatf("rnd%0d_pulses", n), pulses - p0, cnt);
      check($sformatf("rnd%0d_speed", n), speed_o, exp);
      prev = exp;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
